// File: rtl/uart_link_pkg.sv
// Shared definitions for the FPGA-to-FPGA serial link: tag constants, frame FSM states, word width.
package uart_link_pkg;

  localparam int unsigned WORD_W = 17;

  localparam logic [1:0] TAG_B0 = 2'b00;
  localparam logic [1:0] TAG_B1 = 2'b01;
  localparam logic [2:0] TAG_B2 = 3'b100;

  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2
  } rx_frame_state_t;

  typedef enum logic [1:0] {
    TAG_T0,
    TAG_T1,
    TAG_T2,
    TAG_INVALID
  } byte_tag_t;

  // Classify a received byte by its tag prefix.
  function automatic byte_tag_t decode_tag(input logic [7:0] b);
    byte_tag_t t;
    t = TAG_INVALID;
    if (b[7:6] == TAG_B0) begin
      t = TAG_T0;
    end else if (b[7:6] == TAG_B1) begin
      t = TAG_T1;
    end else if (b[7:5] == TAG_B2) begin
      t = TAG_T2;
    end
    return t;
  endfunction

endpackage

// File: rtl/uart_frame_receiver_if.sv
// Output bundle of the frame receiver: reassembled word plus status/handshake pulses.
interface uart_frame_receiver_if;
  import uart_link_pkg::*;

  logic [WORD_W-1:0] data_out;
  logic              valid_out;
  logic              frame_err_out;
  logic              busy_out;
  logic [7:0]        err_count_out;

  modport master (
    output data_out,
    output valid_out,
    output frame_err_out,
    output busy_out,
    output err_count_out
  );

  modport slave (
    input data_out,
    input valid_out,
    input frame_err_out,
    input busy_out,
    input err_count_out
  );
endinterface

// File: rtl/uart_receive.sv
// 8N1 byte receiver: 2-flop line synchronizer plus bit-timing FSM.
module uart_receive #(
  parameter int unsigned BIT_PERIOD = 10416
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_wire_in,
  output logic [7:0] data_byte_out,
  output logic       valid_out,
  output logic       frame_err_out
);

  localparam int unsigned CNT_W = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_PERIOD - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_bit_state_t;

  rx_bit_state_t    state_q, state_d;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_d;
  logic             valid_d;
  logic             err_d;
  logic             rx_s;

  assign rx_s = sync_q[1];

  // Line synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_wire_in};
    end
  end

  // Bit-timing next state: mid-bit sampling referenced to the start edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_byte_out;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= RX_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_byte_out <= '0;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      data_byte_out <= data_d;
      valid_out     <= valid_d;
      frame_err_out <= err_d;
    end
  end

endmodule

// File: rtl/uart_frame_receiver.sv
// Reassembles 3 tagged UART bytes into one 17-bit word.
// Optional macro UART_RX_TIMEOUT_EN: abandon a partial word after TIMEOUT_BITS idle bit periods.
module uart_frame_receiver
  import uart_link_pkg::*;
#(
  parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE        = 9600
`ifdef UART_RX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_BITS     = 30
`endif
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rx_wire_in,
  uart_frame_receiver_if.master  frame_if
);

  localparam int unsigned BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;

  logic [7:0]      byte_data;
  logic            byte_valid;
  logic            byte_err;
  byte_tag_t       tag;
  rx_frame_state_t state_q, state_d;
  logic [5:0]      b0_q, b0_d;
  logic [5:0]      b1_q, b1_d;
  logic [WORD_W-1:0] word_d;
  logic            valid_d;
  logic            err_d;

  uart_receive #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_uart_receive (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rx_wire_in    (rx_wire_in),
    .data_byte_out (byte_data),
    .valid_out     (byte_valid),
    .frame_err_out (byte_err)
  );

  assign tag = decode_tag(byte_data);

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned GAP_LIMIT = TIMEOUT_BITS * BIT_PERIOD;
  localparam int unsigned GAP_W     = (GAP_LIMIT > 2) ? $clog2(GAP_LIMIT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LIMIT - 1);

  logic [GAP_W-1:0] gap_q, gap_d;
  logic             gap_expired;

  assign gap_expired = (state_q != WAIT_B0) && (gap_q == GAP_LAST);

  // Inter-byte gap counter, only running while a word is partial.
  always_comb begin
    gap_d = gap_q + GAP_W'(1);
    if (byte_valid || byte_err || (state_q == WAIT_B0) || gap_expired) begin
      gap_d = '0;
    end
  end

  // Gap counter register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  // Reassembly next state: one outcome (word, error or nothing) per received byte.
  always_comb begin
    state_d = state_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    word_d  = frame_if.data_out;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (byte_err) begin
      err_d   = 1'b1;
      state_d = WAIT_B0;
    end else if (byte_valid) begin
      case (state_q)
        WAIT_B0: begin
          if (tag == TAG_T0) begin
            b0_d    = byte_data[5:0];
            state_d = WAIT_B1;
          end else begin
            err_d = 1'b1;
          end
        end
        WAIT_B1: begin
          if (tag == TAG_T1) begin
            b1_d    = byte_data[5:0];
            state_d = WAIT_B2;
          end else if (tag == TAG_T0) begin
            err_d = 1'b1;
            b0_d  = byte_data[5:0];
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_B0;
          end
        end
        WAIT_B2: begin
          if (tag == TAG_T2) begin
            word_d  = {byte_data[4:0], b1_q, b0_q};
            valid_d = 1'b1;
            state_d = WAIT_B0;
          end else if (tag == TAG_T0) begin
            err_d   = 1'b1;
            b0_d    = byte_data[5:0];
            state_d = WAIT_B1;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_B0;
          end
        end
        default: state_d = WAIT_B0;
      endcase
    end
`ifdef UART_RX_TIMEOUT_EN
    else if (gap_expired) begin
      err_d   = 1'b1;
      state_d = WAIT_B0;
    end
`endif
  end

  // Frame state and registered outputs; error counter saturates.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q                <= WAIT_B0;
      b0_q                   <= '0;
      b1_q                   <= '0;
      frame_if.data_out      <= '0;
      frame_if.valid_out     <= 1'b0;
      frame_if.frame_err_out <= 1'b0;
      frame_if.busy_out      <= 1'b0;
      frame_if.err_count_out <= '0;
    end else begin
      state_q                <= state_d;
      b0_q                   <= b0_d;
      b1_q                   <= b1_d;
      frame_if.data_out      <= word_d;
      frame_if.valid_out     <= valid_d;
      frame_if.frame_err_out <= err_d;
      frame_if.busy_out      <= (state_d != WAIT_B0);
      if (err_d && (frame_if.err_count_out != 8'hFF)) begin
        frame_if.err_count_out <= frame_if.err_count_out + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Bench for uart_frame_receiver: directed table, corner sequences, random frames vs a byte-level model.
module tb_uart_frame_receiver;

  localparam int BIT_P = 10;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic rx_wire_in;

  uart_frame_receiver_if frame_if ();

  uart_frame_receiver #(
    .INPUT_CLOCK_FREQ(1_000_000),
    .BAUD_RATE       (100_000)
  ) u_dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .rx_wire_in(rx_wire_in),
    .frame_if  (frame_if)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Observed pulse counts
  int n_valid = 0;
  int n_err   = 0;

  // Reference model: expected word position, partial fields, outcomes
  int          m_pos   = 0;
  logic [5:0]  m_b0    = '0;
  logic [5:0]  m_b1    = '0;
  logic [16:0] m_word  = '0;
  int          m_cnt   = 0;
  int          m_valid = 0;
  int          m_err   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk_in) begin
    if (frame_if.valid_out) n_valid++;
    if (frame_if.frame_err_out) n_err++;
    if (frame_if.valid_out || frame_if.frame_err_out) begin
      checks++;
      if (frame_if.valid_out && frame_if.frame_err_out) begin
        errors++;
        $display("FAIL exclusive_pulses: valid=1 err=1 required not both");
      end
    end
  end

  function automatic int tag_of(input logic [7:0] b);
    if ((b >> 6) == 0) return 0;
    if ((b >> 6) == 1) return 1;
    if ((b >> 5) == 4) return 2;
    return 3;
  endfunction

  task automatic model_error();
    m_err++;
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop);
    int t;
    if (!stop) begin
      model_error();
      m_pos = 0;
    end else begin
      t = tag_of(b);
      if (t == m_pos) begin
        if (t == 0) m_b0 = b[5:0];
        if (t == 1) m_b1 = b[5:0];
        if (t == 2) begin
          m_word = {b[4:0], m_b1, m_b0};
          m_valid++;
          m_pos = 0;
        end else begin
          m_pos = m_pos + 1;
        end
      end else begin
        model_error();
        if (t == 0) begin
          m_b0  = b[5:0];
          m_pos = 1;
        end else begin
          m_pos = 0;
        end
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Drive one 8N1 byte; a bad stop bit is followed by idle so the line resettles
  task automatic send_byte(input logic [7:0] b, input bit stop, input int gap_bits);
    model_byte(b, stop);
    rx_wire_in = 1'b0;
    wait_cycles(BIT_P);
    for (int i = 0; i < 8; i++) begin
      rx_wire_in = b[i];
      wait_cycles(BIT_P);
    end
    rx_wire_in = stop;
    wait_cycles(BIT_P);
    rx_wire_in = 1'b1;
    wait_cycles(BIT_P * (gap_bits + (stop ? 0 : 2)));
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    wait_cycles(3);
    m_pos  = 0;
    m_word = '0;
    m_cnt  = 0;
    rst_n_in = 1'b1;
    wait_cycles(2);
  endtask

  task automatic settle_and_compare(input string tag);
    wait_cycles(3 * BIT_P);
    check({tag, "_valid_pulses"}, 32'(n_valid), 32'(m_valid));
    check({tag, "_err_pulses"},   32'(n_err),   32'(m_err));
    check({tag, "_data"},         32'(frame_if.data_out), 32'(m_word));
    check({tag, "_err_count"},    32'(frame_if.err_count_out), 32'(m_cnt));
    check({tag, "_busy"},         32'(frame_if.busy_out), 32'(m_pos != 0));
  endtask

  typedef struct {
    logic [7:0]  b [4];
    bit          stop [4];
    int          n;
    logic [16:0] exp_word;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int v0, e0;
    logic [16:0] d;

    vecs[0] = '{b: '{8'h0D, 8'h6F, 8'h9A, 8'h00}, stop: '{1, 1, 1, 1}, n: 3,
                exp_word: 17'h1ABCD, exp_valid: 1, exp_err: 0};
    vecs[1] = '{b: '{8'h0D, 8'h9A, 8'h00, 8'h00}, stop: '{1, 1, 1, 1}, n: 2,
                exp_word: 17'h1ABCD, exp_valid: 0, exp_err: 1};
    vecs[2] = '{b: '{8'h0D, 8'h01, 8'h6F, 8'h9A}, stop: '{1, 1, 1, 1}, n: 4,
                exp_word: 17'h1ABC1, exp_valid: 1, exp_err: 1};
    vecs[3] = '{b: '{8'h0D, 8'h0D, 8'h6F, 8'h9A}, stop: '{0, 1, 1, 1}, n: 4,
                exp_word: 17'h1ABCD, exp_valid: 1, exp_err: 1};

    rx_wire_in = 1'b1;
    rst_n_in   = 1'b0;
    wait_cycles(4);
    check("reset_data",      32'(frame_if.data_out), 32'h0);
    check("reset_valid",     32'(frame_if.valid_out), 32'h0);
    check("reset_err",       32'(frame_if.frame_err_out), 32'h0);
    check("reset_busy",      32'(frame_if.busy_out), 32'h0);
    check("reset_err_count", 32'(frame_if.err_count_out), 32'h0);
    rst_n_in = 1'b1;
    wait_cycles(2);

    // Directed table
    for (int k = 0; k < 4; k++) begin
      v0 = n_valid;
      e0 = n_err;
      for (int j = 0; j < vecs[k].n; j++) send_byte(vecs[k].b[j], vecs[k].stop[j], 0);
      wait_cycles(3 * BIT_P);
      check($sformatf("vec%0d_valid", k), 32'(n_valid - v0), 32'(vecs[k].exp_valid));
      check($sformatf("vec%0d_err", k),   32'(n_err - e0),   32'(vecs[k].exp_err));
      check($sformatf("vec%0d_data", k),  32'(frame_if.data_out), 32'(vecs[k].exp_word));
      settle_and_compare($sformatf("vec%0d_model", k));
    end
    check("vec_err_count", 32'(frame_if.err_count_out), 32'd3);

    // Short low glitch on an idle line yields nothing
    v0 = n_valid;
    e0 = n_err;
    rx_wire_in = 1'b0;
    wait_cycles(2);
    rx_wire_in = 1'b1;
    wait_cycles(3 * BIT_P);
    check("glitch_valid", 32'(n_valid - v0), 32'd0);
    check("glitch_err",   32'(n_err - e0),   32'd0);
    check("glitch_busy",  32'(frame_if.busy_out), 32'd0);

    // Reset mid-frame discards the partial word
    send_byte(8'h0D, 1, 0);
    send_byte(8'h6F, 1, 0);
    check("midframe_busy", 32'(frame_if.busy_out), 32'd1);
    do_reset();
    check("rst_data",      32'(frame_if.data_out), 32'h0);
    check("rst_err_count", 32'(frame_if.err_count_out), 32'h0);
    check("rst_busy",      32'(frame_if.busy_out), 32'h0);
    send_byte(8'h9A, 1, 0);
    settle_and_compare("after_reset");
    check("after_reset_cnt", 32'(frame_if.err_count_out), 32'd1);

`ifdef UART_RX_TIMEOUT_EN
    // Partial word abandoned after the idle limit
    send_byte(8'h0D, 1, 0);
    check("timeout_busy_pre", 32'(frame_if.busy_out), 32'd1);
    e0 = n_err;
    wait_cycles(35 * BIT_P);
    m_pos = 0;
    model_error();
    check("timeout_err",  32'(n_err - e0), 32'd1);
    check("timeout_busy", 32'(frame_if.busy_out), 32'd0);
    settle_and_compare("timeout");
`endif

    // Randomized frames and garbage against the model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        d = 17'($urandom);
        send_byte({2'b00, d[5:0]},   ($urandom_range(0, 9) != 0), $urandom_range(0, 2));
        send_byte({2'b01, d[11:6]},  ($urandom_range(0, 9) != 0), $urandom_range(0, 2));
        send_byte({3'b100, d[16:12]}, ($urandom_range(0, 9) != 0), $urandom_range(0, 2));
      end else begin
        for (int j = 0; j < 2; j++) send_byte(8'($urandom_range(0, 255)), 1, $urandom_range(0, 1));
      end
      if ((it % 8) == 7) settle_and_compare($sformatf("rand%0d", it));
    end
    settle_and_compare("rand_end");

    // Error counter saturation
    do_reset();
    for (int j = 0; j < 300; j++) send_byte(8'hFF, 1, 0);
    settle_and_compare("saturate");
    check("saturate_cnt", 32'(frame_if.err_count_out), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
